// File: rtl/o_serializer_pkg.sv
// Shared types and limits for the o_serializer block.
package o_serializer_pkg;

  // Serializer control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Legal range for the parallel word width
  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 10;

  // Bit counter width: enough to index a frame of WIDTH_MAX+1 bits
  localparam int unsigned CNT_W = $clog2(WIDTH_MAX + 1);

endpackage

// File: rtl/o_serializer.sv
// o_serializer: parallel-to-serial output stage, LSB first, feeding a
// differential output buffer (Q -> I, OE_OUT -> output enable).
// Optional macro O_SERIALIZER_PARITY_EN appends an even-parity bit to
// every frame; without it the frame is exactly WIDTH bits.
module o_serializer
  import o_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter logic        IDLE_VAL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  output logic             Q,
  output logic             OE_OUT
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $fatal(1, "o_serializer: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

`ifdef O_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [FRAME-1:0] sreg_q;
  logic [FRAME-1:0] frame_word;
  logic             accept;

  // Frame contents for the word on D (parity, when enabled, sits above the MSB)
  always_comb begin
    frame_word = '0;
`ifdef O_SERIALIZER_PARITY_EN
    frame_word = {^D, D};
`else
    frame_word = D;
`endif
  end

  // Handshake and counter increment
  always_comb begin
    accept  = DATA_VALID && DATA_READY;
    cnt_inc = cnt_q + 1'b1;
  end

  // Control FSM, bit counter and shifter; bit 0 goes straight to Q on load
  // so the shift register only has to hold the remaining frame bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      Q          <= IDLE_VAL;
      OE_OUT     <= 1'b0;
      DATA_READY <= 1'b0;
    end else if (accept) begin
      state_q    <= SHIFT;
      cnt_q      <= '0;
      Q          <= frame_word[0];
      sreg_q     <= frame_word >> 1;
      OE_OUT     <= 1'b1;
      DATA_READY <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            Q          <= IDLE_VAL;
            OE_OUT     <= 1'b0;
            DATA_READY <= 1'b1;
          end else begin
            cnt_q      <= cnt_inc;
            Q          <= sreg_q[0];
            sreg_q     <= sreg_q >> 1;
            OE_OUT     <= 1'b1;
            DATA_READY <= (cnt_inc == LAST_BIT);
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          Q          <= IDLE_VAL;
          OE_OUT     <= 1'b0;
          DATA_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_o_serializer.sv
// Self-checking bench for o_serializer (WIDTH=4), run with IDLE_VAL=0 and
// IDLE_VAL=1 instances side by side on the same stimulus.
module tb_o_serializer;

`ifdef O_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] D;
  logic       DATA_VALID;
  logic       rdy0, q0, oe0;
  logic       rdy1, q1, oe1;

  int   checks = 0;
  int   errors = 0;
  logic sb[$];
  logic exp_ready = 1'b0;

  always #5 CLK = ~CLK;

  o_serializer #(.WIDTH(4), .IDLE_VAL(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .D(D), .DATA_VALID(DATA_VALID),
    .DATA_READY(rdy0), .Q(q0), .OE_OUT(oe0)
  );

  o_serializer #(.WIDTH(4), .IDLE_VAL(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .D(D), .DATA_VALID(DATA_VALID),
    .DATA_READY(rdy1), .Q(q1), .OE_OUT(oe1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, predict, sample 1 time unit after
  // the rising edge, then return at the next falling edge.
  task automatic cycle(input logic v, input logic [3:0] d, output logic acc);
    logic [FRAME_LEN-1:0] fr;
    logic b;
    logic eq0, eq1, eoe;
    DATA_VALID = v;
    D          = d;
    acc        = v && exp_ready;
`ifdef O_SERIALIZER_PARITY_EN
    fr = {^d, d};
`else
    fr = d;
`endif
    @(posedge CLK);
    if (acc)
      for (int i = 0; i < FRAME_LEN; i++) sb.push_back(fr[i]);
    #1;
    if (sb.size() > 0) begin
      b   = sb.pop_front();
      eq0 = b;
      eq1 = b;
      eoe = 1'b1;
    end else begin
      eq0 = 1'b0;
      eq1 = 1'b1;
      eoe = 1'b0;
    end
    check("q_idle0", q0, eq0);
    check("q_idle1", q1, eq1);
    check("oe0", oe0, eoe);
    check("oe1", oe1, eoe);
    exp_ready = (sb.size() == 0);
    check("ready0", rdy0, exp_ready);
    check("ready1", rdy1, exp_ready);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, a);
  endtask

  // Hold DATA_VALID with d until the word is taken (bounded)
  task automatic send(input logic [3:0] d);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 16 && !a; i++) cycle(1'b1, d, a);
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset pulse, asserted away from the clock edge
  task automatic pulse_reset();
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    #1;
    check("rst_q0", q0, 1'b0);
    check("rst_q1", q1, 1'b1);
    check("rst_oe", oe0 | oe1, 1'b0);
    check("rst_ready", rdy0 | rdy1, 1'b0);
    sb.delete();
    DATA_VALID = 1'b1;
    D          = 4'hF;
    @(posedge CLK);
    #1;
    check("rst_hold_q0", q0, 1'b0);
    check("rst_hold_oe", oe0, 1'b0);
    check("rst_hold_ready", rdy0, 1'b0);
    DATA_VALID = 1'b0;
    @(negedge CLK);
    RST       = 1'b1;
    exp_ready = 1'b0;
  endtask

  initial begin
    logic a;
    RST        = 1'b0;
    DATA_VALID = 1'b0;
    D          = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    check("init_q0", q0, 1'b0);
    check("init_q1", q1, 1'b1);
    check("init_oe", oe0, 1'b0);
    check("init_ready", rdy0, 1'b0);
    RST       = 1'b1;
    exp_ready = 1'b0;

    // Valid presented right after release must not be taken
    cycle(1'b1, 4'h6, a);
    check("post_rst_no_accept", a, 1'b0);
    idle(2);

    // Single word 1011 -> 1,1,0,1 then idle
    send(4'b1011);
    idle(FRAME_LEN + 2);

    // Back-to-back A then 5, contiguous frames
    send(4'hA);
    send(4'h5);
    idle(FRAME_LEN + 2);

    // Word offered mid-frame is ignored
    send(4'hA);
    cycle(1'b0, 4'h0, a);
    cycle(1'b1, 4'hF, a);
    check("midframe_ignored", a, 1'b0);
    idle(FRAME_LEN + 1);

    // Reset during bit 2 of C, then 3 starts from bit 0
    send(4'hC);
    idle(2);
    pulse_reset();
    idle(1);
    send(4'h3);
    idle(FRAME_LEN + 1);

    // Parity-sensitive word
    send(4'b0111);
    idle(FRAME_LEN + 1);

    // Random traffic with gaps
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a);
    idle(FRAME_LEN + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
